// File: rtl/bram_bank_array.sv
// Banked word memory: BANK_NUM interleaved banks with per-lane writes, zero-clear on reset,
// write-first same-address bypass and an optional output pipeline stage.
module bram_bank_array #(
    parameter int unsigned BANK_NUM   = 4,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned LANE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned OUT_REG    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cs,
    input  logic                                 re,
    input  logic [ADDR_WIDTH-1:0]                raddr,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]     we,
    input  logic [ADDR_WIDTH-1:0]                waddr,
    input  logic [DATA_WIDTH-1:0]                din,
    output logic [DATA_WIDTH-1:0]                dout,
    output logic                                 dout_vld,
    output logic                                 addr_err,
    output logic                                 init_done
);

    localparam int unsigned LANES     = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned BANK_BITS = $clog2(BANK_NUM);
    localparam int unsigned ROW_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CAP       = BANK_NUM * DEPTH;

    localparam logic [ADDR_WIDTH-1:0] CAP_A    = ADDR_WIDTH'(CAP);
    localparam logic [ROW_BITS-1:0]   LAST_ROW = ROW_BITS'(DEPTH - 1);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [ROW_BITS-1:0]   init_row;
    logic [ROW_BITS-1:0]   init_row_nxt;
    logic                  clr_en;
    logic                  ready;

    logic [DATA_WIDTH-1:0] mem [BANK_NUM][DEPTH];

    logic                  rd_oor;
    logic                  wr_oor;
    logic                  rd_acc;
    logic                  wr_any;
    logic                  wr_acc;
    logic                  wr_err;
    logic [BANK_BITS-1:0]  rbank;
    logic [BANK_BITS-1:0]  wbank;
    logic [ROW_BITS-1:0]   rrow;
    logic [ROW_BITS-1:0]   wrow;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  fin_vld;
    logic                  fin_err;
    logic [DATA_WIDTH-1:0] fin_data;

    // State and clear-row counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_row <= '0;
        end else begin
            state    <= state_nxt;
            init_row <= init_row_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_row_nxt = init_row;
        clr_en       = 1'b0;
        ready        = 1'b0;
        case (state)
            ST_INIT: begin
                clr_en       = 1'b1;
                init_row_nxt = init_row + ROW_BITS'(1);
                if (init_row == LAST_ROW) begin
                    state_nxt    = ST_READY;
                    init_row_nxt = '0;
                end
            end
            ST_READY: ready = 1'b1;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Request decode: bank is the low address bits, row the remainder
    always_comb begin
        rd_oor = (raddr >= CAP_A);
        wr_oor = (waddr >= CAP_A);
        rd_acc = ready && cs && re;
        wr_any = ready && cs && (we != '0);
        wr_acc = wr_any && !wr_oor;
        wr_err = wr_any && wr_oor;
        rbank  = raddr[BANK_BITS-1:0];
        wbank  = waddr[BANK_BITS-1:0];
        rrow   = ROW_BITS'(raddr >> BANK_BITS);
        wrow   = ROW_BITS'(waddr >> BANK_BITS);
    end

    always_ff @(posedge clk) begin
        if (!rst && clr_en) begin
            for (int b = 0; b < int'(BANK_NUM); b++) begin
                mem[BANK_BITS'(b)][init_row] <= '0;
            end
        end else if (!rst && wr_acc) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (we[l]) begin
                    mem[wbank][wrow][l*LANE_WIDTH +: LANE_WIDTH] <= din[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Write-first per lane on a same-address collision; out-of-range reads return zero
    always_comb begin
        rd_word = mem[rbank][rrow];
        for (int l = 0; l < int'(LANES); l++) begin
            if (wr_acc && (waddr == raddr) && we[l]) begin
                rd_word[l*LANE_WIDTH +: LANE_WIDTH] = din[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        if (rd_oor) begin
            rd_word = '0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  s1_vld;
            logic                  s1_err;
            logic [DATA_WIDTH-1:0] s1_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_vld  <= 1'b0;
                    s1_err  <= 1'b0;
                    s1_data <= '0;
                end else begin
                    s1_vld <= rd_acc;
                    s1_err <= rd_acc && rd_oor;
                    if (rd_acc) begin
                        s1_data <= rd_word;
                    end
                end
            end

            assign fin_vld  = s1_vld;
            assign fin_err  = s1_err;
            assign fin_data = s1_data;
        end else begin : g_noreg
            assign fin_vld  = rd_acc;
            assign fin_err  = rd_acc && rd_oor;
            assign fin_data = rd_word;
        end
    endgenerate

    // Output stage: dout holds between completed reads; read and write errors merge into one flag
    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= '0;
            dout_vld  <= 1'b0;
            addr_err  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            dout_vld  <= fin_vld;
            addr_err  <= fin_err || wr_err;
            init_done <= (state_nxt == ST_READY);
            if (fin_vld) begin
                dout <= fin_data;
            end
        end
    end

endmodule

// File: tb/tb_bram_bank_array.sv
// Randomized bench for bram_bank_array against a flat-array reference model with
// per-cycle scheduled expectations for dout, dout_vld, addr_err and init_done.
module tb_bram_bank_array;

    localparam int unsigned BANK_NUM   = 4;
    localparam int unsigned DEPTH      = 32;
    localparam int unsigned DATA_WIDTH = 24;
    localparam int unsigned LANE_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned OUT_REG    = 1;
    localparam int unsigned LANES      = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned CAP        = BANK_NUM * DEPTH;
    localparam int unsigned LAT        = (OUT_REG != 0) ? 2 : 1;
    localparam int unsigned MAXC       = 8192;

    logic                  clk;
    logic                  rst;
    logic                  cs;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [LANES-1:0]      we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;
    logic                  addr_err;
    logic                  init_done;

    bram_bank_array #(
        .BANK_NUM  (BANK_NUM),
        .DEPTH     (DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LANE_WIDTH(LANE_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .OUT_REG   (OUT_REG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .re       (re),
        .raddr    (raddr),
        .we       (we),
        .waddr    (waddr),
        .din      (din),
        .dout     (dout),
        .dout_vld (dout_vld),
        .addr_err (addr_err),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [DATA_WIDTH-1:0] mdl_mem  [CAP];
    bit                    sch_vld  [MAXC];
    logic [DATA_WIDTH-1:0] sch_data [MAXC];
    bit                    sch_err  [MAXC];
    bit                    mdl_ready = 1'b0;
    int                    init_left = 0;
    logic [DATA_WIDTH-1:0] exp_dout  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [LANES-1:0] w);
        logic [DATA_WIDTH-1:0] m;
        for (int l = 0; l < int'(LANES); l++) m[l*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{w[l]}};
        return m;
    endfunction

    task automatic idle();
        cs = 1'b0; re = 1'b0; we = '0;
    endtask

    // One clock: advance the model with the inputs seen at this edge, then compare outputs
    task automatic step();
        logic [DATA_WIDTH-1:0] word;
        logic [DATA_WIDTH-1:0] m;
        bit wr_ok;
        bit e_vld;
        bit e_err;
        int t;
        @(posedge clk);
        cyc++;
        if (cyc + int'(LAT) + 1 >= int'(MAXC)) begin
            $display("FAIL cycle_budget: got %0d, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        if (rst) begin
            mdl_ready = 1'b0;
            init_left = DEPTH;
            for (int i = 0; i < int'(CAP); i++) mdl_mem[i] = '0;
            for (int i = cyc; i <= cyc + int'(LAT); i++) begin
                sch_vld[i] = 1'b0; sch_err[i] = 1'b0;
            end
            exp_dout = '0;
        end else if (!mdl_ready) begin
            init_left--;
            if (init_left == 0) mdl_ready = 1'b1;
        end else if (cs) begin
            wr_ok = (we != '0) && (waddr < CAP);
            m     = lane_mask(we);
            if (re) begin
                if (raddr < CAP) begin
                    word = mdl_mem[raddr];
                    if (wr_ok && waddr == raddr) word = (word & ~m) | (din & m);
                end else begin
                    word = '0;
                end
                t = cyc + int'(LAT) - 1;
                sch_vld[t]  = 1'b1;
                sch_data[t] = word;
                if (raddr >= CAP) sch_err[t] = 1'b1;
            end
            if (wr_ok) mdl_mem[waddr] = (mdl_mem[waddr] & ~m) | (din & m);
            if ((we != '0) && (waddr >= CAP)) sch_err[cyc] = 1'b1;
        end
        e_vld = !rst && sch_vld[cyc];
        e_err = !rst && sch_err[cyc];
        if (e_vld) exp_dout = sch_data[cyc];
        sch_vld[cyc] = 1'b0;
        sch_err[cyc] = 1'b0;
        #1;
        chk("dout_vld", 32'(dout_vld), 32'(e_vld));
        chk("addr_err", 32'(addr_err), 32'(e_err));
        chk("init_done", 32'(init_done), 32'(mdl_ready));
        chk("dout", 32'(dout), 32'(exp_dout));
    endtask

    // Issue one read (alongside whatever write is set up) and measure its latency
    task automatic rd_chk(input string tag, input logic [ADDR_WIDTH-1:0] a,
                          input logic [DATA_WIDTH-1:0] expv);
        int k;
        cs = 1'b1; re = 1'b1; raddr = a;
        step();
        idle();
        k = 1;
        while (!dout_vld && k < 8) begin
            step();
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(LAT));
        chk({tag, "_data"}, 32'(dout), 32'(expv));
    endtask

    int n;

    initial begin
        rst = 1'b1; cs = 1'b0; re = 1'b0; we = '0;
        raddr = '0; waddr = '0; din = '0;
        repeat (3) step();
        rst = 1'b0;

        // Traffic during the clear must be ignored
        n = 0;
        while (!init_done && n < 100) begin
            cs = 1'b1; re = 1'b1; we = LANES'($urandom);
            raddr = $urandom_range(0, 255); waddr = $urandom_range(0, 255);
            din = DATA_WIDTH'($urandom);
            step();
            n++;
        end
        idle();
        chk("init_cycles", 32'(n), 32'(DEPTH));

        for (int i = 0; i < int'(CAP); i++) begin
            cs = 1'b1; re = 1'b1; raddr = i;
            step();
        end
        idle();
        repeat (LAT) step();

        cs = 1'b1; we = '1; waddr = 5; din = 24'hA1B2C3;
        step();
        idle();
        step();
        rd_chk("rd5", 5, 24'hA1B2C3);

        cs = 1'b1; we = '1; waddr = 9; din = 24'h112233;
        step();
        idle();
        cs = 1'b1; we = 3'b010; waddr = 9; din = 24'hFFEEDD;
        rd_chk("wfirst9", 9, 24'h11EE33);

        for (int i = 0; i < 4; i++) begin
            cs = 1'b1; we = '1; waddr = i; din = DATA_WIDTH'(32'h10_2030 * (i + 1));
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            cs = 1'b1; re = 1'b1; raddr = i;
            step();
        end
        idle();
        repeat (LAT + 1) step();

        cs = 1'b1; re = 1'b1; raddr = 128; we = '1; waddr = 200; din = 24'h5A5A5A;
        step();
        idle();
        repeat (LAT + 1) step();

        for (int r = 0; r < 3000; r++) begin
            rst   = ($urandom_range(0, 499) == 0);
            cs    = ($urandom_range(0, 7) != 0);
            re    = 1'($urandom_range(0, 1));
            we    = ($urandom_range(0, 2) == 0) ? '0 : LANES'($urandom);
            raddr = $urandom_range(0, CAP + 31);
            waddr = ($urandom_range(0, 3) == 0) ? raddr : $urandom_range(0, CAP + 31);
            din   = DATA_WIDTH'($urandom);
            step();
        end
        rst = 1'b0;
        idle();
        n = 0;
        while (!init_done && n < 100) begin
            step();
            n++;
        end
        chk("ready_after_random", 32'(init_done), 32'(1));

        cs = 1'b1; we = '1; waddr = 5; din = 24'h5A5A5A;
        step();
        idle();
        cs = 1'b1; re = 1'b1; raddr = 5;
        step();
        raddr = 6;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        n = 0;
        while (!init_done && n < 100) begin
            step();
            n++;
        end
        chk("reinit_cycles", 32'(n), 32'(DEPTH));
        rd_chk("rd5_cleared", 5, 24'h000000);

        for (int i = 0; i < int'(CAP); i++) begin
            cs = 1'b1; re = 1'b1; raddr = i;
            step();
        end
        idle();
        repeat (LAT + 1) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_bank_array.md
BRAM_BANK_ARRAY -- requirements
Module: bram_bank_array

Interface
REQ-001 SHALL have parameter BANK_NUM, default 4: number of interleaved sub-banks (power of two, >=2).
REQ-002 SHALL have parameter DEPTH, default 32: words per bank.
REQ-003 SHALL have parameter DATA_WIDTH, default 24: word width.
REQ-004 SHALL have parameter LANE_WIDTH, default 8: byte-lane width. DATA_WIDTH is an integer multiple of it. LANES = DATA_WIDTH/LANE_WIDTH.
REQ-005 SHALL have parameter ADDR_WIDTH, default 32: flat word-address width.
REQ-006 SHALL have parameter OUT_REG, default 1: 1 adds an output pipeline register.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock, all logic on rising edge.
REQ-008 SHALL have rst  input  1  synchronous active-high reset.
REQ-009 SHALL have cs  input  1  chip select, gates re and we.
REQ-010 SHALL have re  input  1  read request.
REQ-011 SHALL have raddr  input  ADDR_WIDTH  read word address.
REQ-012 SHALL have we  input  LANES  per-lane write enable.
REQ-013 SHALL have waddr  input  ADDR_WIDTH  write word address.
REQ-014 SHALL have din  input  DATA_WIDTH  write data.
REQ-015 SHALL have dout  output  DATA_WIDTH  read data, held until the next read completes.
REQ-016 SHALL have dout_vld  output  1  one-cycle pulse marking new dout.
REQ-017 SHALL have addr_err  output  1  one-cycle pulse flagging an out-of-range access.
REQ-018 SHALL have init_done  output  1  high once the memory clear has finished.

Function
REQ-019 Address map SHALL be: bank = addr mod BANK_NUM, row = addr / BANK_NUM; capacity CAP = BANK_NUM*DEPTH.
REQ-020 State machine SHALL have states INIT and READY; reset enters INIT with row counter 0.
REQ-021 In INIT, each cycle SHALL write zero to the current row in all banks and increment the counter; after row DEPTH-1 it SHALL move to READY next cycle (exactly DEPTH INIT cycles).
REQ-022 In INIT, cs/re/we SHALL be ignored: no reads, no user writes, no dout_vld, no addr_err.
REQ-023 init_done SHALL be 0 in INIT and 1 in READY.
REQ-024 A write SHALL occur in READY when cs=1, we!=0 and waddr<CAP; only lanes with we[i]=1 are updated.
REQ-025 A read SHALL be accepted in READY when cs=1, re=1 and raddr<CAP; one read and one write SHALL be accepted per cycle, to any banks.
REQ-026 Read latency SHALL be 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), measured from the accepting edge to the dout_vld=1 cycle; reads are fully pipelined at one per cycle.
REQ-027 Same-cycle read and write to the same address SHALL be write-first per lane: written lanes return din, unwritten lanes return the old contents.
REQ-028 An out-of-range read (raddr>=CAP) SHALL produce dout=0 with dout_vld=1 at normal latency, and addr_err=1 in the same cycle as that dout_vld.
REQ-029 An out-of-range write SHALL be dropped, with addr_err=1 on the cycle after the request.
REQ-030 If an out-of-range read and an out-of-range write occur in the same cycle, addr_err SHALL assert for each event in its own cycle; if those cycles coincide, addr_err is a single pulse.
REQ-031 When no read completes in a cycle, dout SHALL hold its value and dout_vld SHALL be 0.
REQ-032 we=0 with re=0 SHALL be a no-op.
REQ-033 cs=0 SHALL block both reads and writes regardless of re and we.

Reset
REQ-034 When rst=1 on a clock edge: dout=0, dout_vld=0, addr_err=0, init_done=0, FSM=INIT, counter=0, and in-flight pipeline reads are discarded.
REQ-035 Asserting rst mid-operation or mid-INIT SHALL restart a full DEPTH-cycle clear; memory contents SHALL be zero once init_done rises.

Verification
REQ-036 Release rst with defaults -> init_done rises after exactly 32 cycles; cs/re pulsed during INIT gives no dout_vld; reading addr 0..127 then returns 0.
REQ-037 Write 0xA1B2C3 to addr 5 with we=3'b111, then read 5 -> dout=0xA1B2C3 with dout_vld exactly 2 cycles after the read (OUT_REG=1) and exactly 1 cycle after it (OUT_REG=0).
REQ-038 addr 9 holds 0x112233; same cycle we=3'b010 din=0xFFEEDD waddr=9 and re raddr=9 -> dout=0x11EE33.
REQ-039 Back-to-back reads of addrs 0,1,2,3 (all 4 banks) on consecutive cycles -> four consecutive dout_vld pulses with data in order.
REQ-040 Read addr 128 and write addr 200 in the same cycle -> dout=0 with dout_vld and addr_err at read latency, addr_err on the cycle after the write, and memory unchanged.
REQ-041 Assert rst while 2 reads are in flight -> no dout_vld afterwards; 32 INIT cycles follow; previously written addr 5 reads 0.
